// File: rtl/input_cond_pkg.sv
// Shared defaults, legal parameter ranges and counter sizing for input_conditioner.
package input_cond_pkg;

    localparam int DEF_W        = 8;
    localparam int DEF_STAGES   = 2;
    localparam int DEF_FILT_LEN = 3;

    localparam int STAGES_MIN   = 2;
    localparam int STAGES_MAX   = 4;
    localparam int FILT_LEN_MIN = 1;
    localparam int FILT_LEN_MAX = 255;

    // Counter must hold values 0..filt_len-1; one extra state keeps FILT_LEN=1 at width 1.
    function automatic int cnt_width(input int filt_len);
        return (filt_len < 1) ? 1 : $clog2(filt_len + 1);
    endfunction

    function automatic bit params_legal(input int stages, input int filt_len);
        return (stages >= STAGES_MIN) && (stages <= STAGES_MAX) &&
               (filt_len >= FILT_LEN_MIN) && (filt_len <= FILT_LEN_MAX);
    endfunction

endpackage

// File: rtl/input_conditioner_sync_chain.sv
// W-bit, STAGES-deep metastability synchroniser; async reset loads RESET_VAL into every stage.
module sync_chain #(
    parameter int             W         = 8,
    parameter int             STAGES    = 2,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= {STAGES{RESET_VAL}};
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronise, glitch-filter and edge-detect W asynchronous pins; strobes coincide with the new pin_out.
// INPUT_COND_FILTER_EN enables the FILT_LEN persistence filter; otherwise pin_out follows s_last every edge.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int           W         = DEF_W,
    parameter int           STAGES    = DEF_STAGES,
    parameter int           FILT_LEN  = DEF_FILT_LEN,
    parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
    input  logic         eclk,
    input  logic         ereset_n,
    input  logic [W-1:0] pin_in,
    output logic [W-1:0] pin_out,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall,
    output logic         any_change
);

    if (!params_legal(STAGES, FILT_LEN)) begin : g_param_check
        $error("input_conditioner: STAGES or FILT_LEN outside legal range");
    end

    logic [W-1:0] s_last;
    logic [W-1:0] pin_nxt;

    sync_chain #(
        .W         (W),
        .STAGES    (STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk   (eclk),
        .rst_n (ereset_n),
        .d     (pin_in),
        .q     (s_last)
    );

`ifdef INPUT_COND_FILTER_EN
    localparam int             CW      = cnt_width(FILT_LEN);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_LEN - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic [W-1:0][CW-1:0] cnt;
    logic [W-1:0][CW-1:0] cnt_nxt;

    // Any return of s_last to pin_out clears the run, so only uninterrupted runs are accepted.
    always_comb begin
        pin_nxt = pin_out;
        cnt_nxt = cnt;
        for (int i = 0; i < W; i++) begin
            if (s_last[i] == pin_out[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                pin_nxt[i] = s_last[i];
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    assign pin_nxt = s_last;
`endif

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            pin_out    <= RESET_VAL;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else begin
            pin_out    <= pin_nxt;
            rise       <= pin_nxt & ~pin_out;
            fall       <= ~pin_nxt & pin_out;
            any_change <= |(pin_nxt ^ pin_out);
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner against a sample-history window model.
module tb_input_conditioner;

    localparam int W        = 8;
    localparam int STAGES   = 2;
    localparam int FILT_LEN = 3;
`ifdef INPUT_COND_FILTER_EN
    localparam int FL = FILT_LEN;
`else
    localparam int FL = 1;
`endif
    localparam int           LAT = STAGES + FL;
    localparam logic [W-1:0] RV  = '0;
    localparam int           HN  = 4096;

    logic         eclk     = 1'b0;
    logic         ereset_n = 1'b0;
    logic [W-1:0] pin_in   = 8'hFF;
    logic [W-1:0] pin_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any_change;

    always #5 eclk = ~eclk;

    input_conditioner #(
        .W         (W),
        .STAGES    (STAGES),
        .FILT_LEN  (FILT_LEN),
        .RESET_VAL (RV)
    ) dut (
        .eclk       (eclk),
        .ereset_n   (ereset_n),
        .pin_in     (pin_in),
        .pin_out    (pin_out),
        .rise       (rise),
        .fall       (fall),
        .any_change (any_change)
    );

    // Model: pin_in samples since reset; the level seen by the filter at edge e is the sample
    // taken STAGES edges earlier. A bit flips once its last FL filter inputs all disagree with it.
    logic [W-1:0] hist [HN];
    int           ec;
    logic [W-1:0] m_po;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    logic         m_any;

    function automatic logic [W-1:0] s_at(input int e);
        return (e >= STAGES) ? hist[(e - STAGES) % HN] : RV;
    endfunction

    function automatic logic [W-1:0] model_next(input int e, input logic [W-1:0] po);
        logic [W-1:0] nxt;
        logic [W-1:0] s;
        logic         all_diff;
        nxt = po;
        if (e + 1 >= FL) begin
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < FL; j++) begin
                    s = s_at(e - j);
                    if (s[b] == po[b]) all_diff = 1'b0;
                end
                if (all_diff) nxt[b] = ~po[b];
            end
        end
        return nxt;
    endfunction

    always @(posedge eclk) begin
        if (!ereset_n) begin
            ec     <= 0;
            m_po   <= RV;
            m_rise <= '0;
            m_fall <= '0;
            m_any  <= 1'b0;
        end else begin
            m_po   <= model_next(ec, m_po);
            m_rise <= model_next(ec, m_po) & ~m_po;
            m_fall <= ~model_next(ec, m_po) & m_po;
            m_any  <= |(model_next(ec, m_po) ^ m_po);
            hist[ec % HN] <= pin_in;
            ec     <= ec + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int rise_tot [W];
    int fall_tot [W];
    int any_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // One cycle: compare against the model at the falling edge, then leave room to drive inputs.
    task automatic step();
        @(negedge eclk);
        chk("pin_out", 32'(pin_out), 32'(m_po));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("any_change", 32'(any_change), 32'(m_any));
        for (int b = 0; b < W; b++) begin
            rise_tot[b] += int'(rise[b]);
            fall_tot[b] += int'(fall[b]);
        end
        any_tot += int'(any_change);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Runs 20 cycles; reports the first cycle pin_out equals target (99 if never) and strobes then.
    task automatic measure(input logic [W-1:0] target, output int lat,
                           output logic [W-1:0] r_at, output logic [W-1:0] f_at);
        lat  = 99;
        r_at = '0;
        f_at = '0;
        for (int j = 1; j <= 20; j++) begin
            step();
            if (lat == 99 && pin_out == target) begin
                lat  = j;
                r_at = rise;
                f_at = fall;
            end
        end
    endtask

    initial begin
        int           r0 [W];
        int           f0 [W];
        int           a0;
        int           lat;
        int           first7;
        logic [W-1:0] r_at;
        logic [W-1:0] f_at;

        for (int b = 0; b < W; b++) begin
            rise_tot[b] = 0;
            fall_tot[b] = 0;
        end

        // Reset held with all pins high
        ereset_n = 1'b0;
        pin_in   = 8'hFF;
        step_n(3);
        chk("reset pin_out", 32'(pin_out), 32'h00);
        chk("reset strobes", 32'({rise, fall, any_change}), 32'h0);

        a0 = any_tot;
        ereset_n = 1'b1;
        measure(8'hFF, lat, r_at, f_at);
        chk("release latency", 32'(lat), 32'(LAT));
        chk("release rise", 32'(r_at), 32'hFF);
        chk("release any_change count", 32'(any_tot - a0), 32'd1);

        // Glitches on channel 3
        pin_in = 8'h00;
        step_n(12);
        r0 = rise_tot;
        f0 = fall_tot;
        pin_in[3] = 1'b1;
        step_n(2);
        pin_in[3] = 1'b0;
        step_n(12);
        chk("2-cycle pulse rise3", 32'(rise_tot[3] - r0[3]), (FL <= 2) ? 32'd1 : 32'd0);
        chk("2-cycle pulse pin_out", 32'(pin_out), 32'h00);

        r0 = rise_tot;
        f0 = fall_tot;
        pin_in[3] = 1'b1;
        step_n(12);
        chk("3-cycle high rise3", 32'(rise_tot[3] - r0[3]), 32'd1);
        chk("3-cycle high pin_out3", 32'(pin_out[3]), 32'd1);
        pin_in[3] = 1'b0;
        step_n(3);
        pin_in[3] = 1'b1;
        step_n(12);
        chk("3-cycle low fall3", 32'(fall_tot[3] - f0[3]), 32'd1);

        // Bounce on channel 0: 1,1,0,1,1,1 then hold
        pin_in = 8'h00;
        step_n(12);
        r0 = rise_tot;
        f0 = fall_tot;
        for (int i = 0; i < 6; i++) begin
            pin_in[0] = (i != 2);
            step();
        end
        step_n(12);
        chk("bounce rise0", 32'(rise_tot[0] - r0[0]), (FL == 1) ? 32'd2 : 32'd1);
        chk("bounce fall0", 32'(fall_tot[0] - f0[0]), (FL == 1) ? 32'd1 : 32'd0);

        // Simultaneous opposite changes
        pin_in = 8'h0F;
        step_n(12);
        a0 = any_tot;
        pin_in = 8'hF0;
        measure(8'hF0, lat, r_at, f_at);
        chk("simul latency", 32'(lat), 32'(LAT));
        chk("simul rise", 32'(r_at), 32'hF0);
        chk("simul fall", 32'(f_at), 32'h0F);
        chk("simul any_change count", 32'(any_tot - a0), 32'd1);

        // Reset one cycle before acceptance
        pin_in = 8'hFF;
        step_n(LAT - 1);
        chk("pre-accept pin_out", 32'(pin_out), 32'hF0);
        ereset_n = 1'b0;
        #1;
        chk("async reset pin_out", 32'(pin_out), 32'h00);
        a0 = any_tot;
        step_n(2);
        chk("mid-filter reset no strobe", 32'(any_tot - a0), 32'd0);
        ereset_n = 1'b1;
        measure(8'hFF, lat, r_at, f_at);
        chk("restart latency", 32'(lat), 32'(LAT));
        chk("restart rise", 32'(r_at), 32'hFF);

        // Single-cycle pulse on channel 7
        pin_in = 8'h00;
        step_n(12);
        f0 = fall_tot;
        first7 = 0;
        pin_in[7] = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            step();
            pin_in[7] = 1'b0;
            if (first7 == 0 && rise[7]) first7 = j;
        end
        chk("1-cycle pulse rise7 edge", 32'(first7), (FL == 1) ? 32'(STAGES + 1) : 32'd0);
        chk("1-cycle pulse fall7", 32'(fall_tot[7] - f0[7]), (FL == 1) ? 32'd1 : 32'd0);

        // Random pin activity with occasional resets
        for (int i = 0; i < 2000; i++) begin
            ereset_n = ($urandom_range(0, 150) != 0);
            pin_in   = pin_in ^ W'($urandom & $urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Multi-channel input conditioner for asynchronous board pins (bus data, reset, IRQ/NMI, RDY, SO, external clock): synchronises W pins into the emulation clock domain, rejects glitches shorter than a programmable length, and produces one-cycle rise/fall strobes per channel plus a global change strobe. It sits between the DIL40 pads and the chip model in every board top-level, replacing ad-hoc single-register pin sampling with a parametrised, metastability-safe, filtered path.

## Interface
- W, 8: number of channels.
- STAGES, 2: synchroniser depth, legal range 2..4.
- FILT_LEN, 3: consecutive cycles a new synchronised value must persist before it is accepted, legal range 1..255.
- RESET_VAL, {W{1'b0}}: value of synchroniser stages and pin_out while in reset.

- eclk  in  1  emulation clock; all state on rising edge.
- ereset_n  in  1  asynchronous, active-low reset; deassertion is synchronised to eclk outside this block.
- pin_in  in  W  raw asynchronous pin levels.
- pin_out  out  W  conditioned, filtered pin levels.
- rise  out  W  one-cycle pulse per channel when pin_out goes 0->1.
- fall  out  W  one-cycle pulse per channel when pin_out goes 1->0.
- any_change  out  1  one-cycle pulse when any bit of rise or fall is set.

## Operation
- Synchroniser: per channel, STAGES flops in series; s_last = final stage.
- Filter, per channel, counter cnt of width clog2(FILT_LEN+1):
  - s_last == pin_out: cnt <= 0.
  - s_last != pin_out and cnt == FILT_LEN-1: pin_out <= s_last, cnt <= 0, rise or fall pulses this edge.
  - otherwise: cnt <= cnt + 1.
- cnt never exceeds FILT_LEN-1; no wrap possible.
- Channels fully independent; simultaneous changes on several channels each produce their own strobe; any_change is a single pulse for all.
- Bouncing input: any return of s_last to pin_out before acceptance clears cnt; restart from zero.
- rise, fall, any_change registered and coincident with the cycle the new pin_out value first appears.

## Timing
- Reset (async, any time, including mid-filter): all sync stages and pin_out = RESET_VAL, cnt = 0, rise = fall = 0, any_change = 0.
- Latency from stable pin_in change (setup met before edge k) to pin_out: STAGES + FILT_LEN edges, i.e. new value visible after edge k+STAGES+FILT_LEN-1.
- Minimum accepted pulse width at s_last: FILT_LEN cycles; shorter pulses produce no output change and no strobe.
- pin_in != RESET_VAL at reset release: treated as a normal change; pin_out follows after STAGES + FILT_LEN edges with rise/fall strobe (not suppressed).
- No handshake; strobes are not held, consumers must sample every cycle.

## Configuration
- INPUT_COND_FILTER_EN defined: glitch filter as above.
- Undefined: counters removed; pin_out <= s_last every edge (latency STAGES + 1, identical to FILT_LEN = 1); FILT_LEN ignored; rise/fall/any_change derived from pin_out transitions identically.

## Structure
- Package input_cond_pkg: default constants (W, STAGES, FILT_LEN), counter-width function, STAGES/FILT_LEN legal-range limits checked at elaboration.
- One sub-module: sync_chain (W-bit, STAGES-deep, async reset to RESET_VAL), instantiated once; filter and strobe logic in input_conditioner.

## Test plan
- Reset: hold ereset_n low with pin_in = 8'hFF -> pin_out = 8'h00, strobes 0; release -> pin_out = 8'hFF after STAGES+FILT_LEN (5) edges with rise = 8'hFF and any_change for exactly one cycle.
- Glitch: pin_in[3] high for 2 cycles (FILT_LEN = 3) -> pin_out, rise, fall unchanged; high for 3 cycles -> pin_out[3] = 1 after 5 edges, rise[3] one pulse; later low for 3 cycles -> fall[3] one pulse.
- Bounce: pin_in[0] toggles 1,1,0,1,1,1 -> single rise[0] only after the final three-cycle run completes; no fall.
- Simultaneous: pin_in 8'h0F -> 8'hF0 -> rise = 8'hF0 and fall = 8'h0F in the same cycle, any_change single pulse.
- Reset mid-filter: assert ereset_n low one cycle before acceptance -> outputs immediately RESET_VAL, no strobe; after release, full STAGES+FILT_LEN latency restarts.
- Macro off: INPUT_COND_FILTER_EN undefined, 1-cycle pulse on pin_in[7] -> pin_out[7] mirrors it after STAGES+1 edges with rise then fall pulses.
